// File: rtl/io_input_responder.sv
// Responder for the CPU Input instruction: stalls the CPU until a debounced Enter press, then returns the switch word.
// Optional build macro IO_INPUT_SIGNED_EN sign-extends the switch bank instead of zero-extending it.
module io_input_responder #(
  parameter int unsigned SW_WIDTH        = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic                  in_req,
  input  logic                  Enter,
  input  logic [SW_WIDTH-1:0]   sw,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_valid,
  output logic                  busy
);

  localparam int unsigned      CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RELEASE,
    WAIT_PRESS,
    DEBOUNCE,
    DONE
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    enter_sync1;
  logic                    enter_sync2;
  logic                    pressed;
  logic [DATA_WIDTH-1:0]   sw_ext;

  assign pressed = ~enter_sync2;

`ifdef IO_INPUT_SIGNED_EN
  assign sw_ext = DATA_WIDTH'($signed(sw));
`else
  assign sw_ext = DATA_WIDTH'(sw);
`endif

  // Two-flop synchronizer for the asynchronous pushbutton; resets to released.
  always_ff @(posedge Clock) begin
    if (reset) begin
      enter_sync1 <= 1'b1;
      enter_sync2 <= 1'b1;
    end else begin
      enter_sync1 <= Enter;
      enter_sync2 <= enter_sync1;
    end
  end

  // Request FSM; dropping in_req in any waiting state abandons the request silently.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      in_data  <= '0;
      in_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      in_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_req) begin
            state <= WAIT_RELEASE;
            busy  <= 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!in_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!pressed) begin
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!in_req) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (pressed) begin
            state <= DEBOUNCE;
            cnt   <= CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!in_req) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (!pressed) begin
            state <= WAIT_PRESS;
            cnt   <= '0;
          end else if (cnt >= CNT_MAX) begin
            state    <= DONE;
            in_data  <= sw_ext;
            in_valid <= 1'b1;
            cnt      <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Stall follows in_req directly in IDLE so the PC freezes on the request cycle itself.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:                             stall = in_req;
        WAIT_RELEASE, WAIT_PRESS, DEBOUNCE: stall = 1'b1;
        default:                          stall = 1'b0;
      endcase
    end
  end

endmodule
